mult_div_unit: RTL
==================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameters: none; datapath fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 start  input  1  request a new operation; sampled on rising clk.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 rs_data  input  32  operand A (multiplicand / dividend), from register-file read port 1.
REQ-007 rt_data  input  32  operand B (multiplier / divisor), from register-file read port 2.
REQ-008 hilo_we  input  1  direct write to HI or LO (MTHI/MTLO).
REQ-009 hilo_sel  input  1  hilo_we target: 0 LO, 1 HI.
REQ-010 hilo_wdata  input  32  data for the hilo_we write.
REQ-011 busy  output  1  high while an operation is executing.
REQ-012 done  output  1  one-cycle pulse when the result has been committed to HI/LO.
REQ-013 hi  output  32  HI register (MFHI source).
REQ-014 lo  output  32  LO register (MFLO source).

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE; IDLE->RUN on start, RUN->DONE after 32 iterations, DONE->IDLE unconditionally on the next edge.
REQ-016 start SHALL be accepted only in IDLE; at the accepting edge E0, op, rs_data and rt_data SHALL be captured and the iteration counter cleared.
REQ-017 start in RUN or DONE SHALL be ignored, with no queuing.
REQ-018 busy SHALL be 1 exactly in RUN: the 32 cycles following E0.
REQ-019 At edge E32, the 32nd edge after E0, hi/lo SHALL load the result, the FSM SHALL enter DONE, and done SHALL be 1 for that single cycle.
REQ-020 Latency SHALL be fixed at 32 cycles regardless of op or operand values, including a zero divisor.
REQ-021 hi/lo SHALL NOT change during RUN; partial products and remainders live in internal registers only.
REQ-022 Multiply: iterative shift-add, one bit per cycle, on operand magnitudes; {HI,LO} = 64-bit product.
REQ-023 MULT: operands treated as signed; the product is negated when the operand signs differ.
REQ-024 MULTU: operands treated as unsigned.
REQ-025 Divide: restoring, one quotient bit per cycle, on magnitudes; LO = quotient, HI = remainder.
REQ-026 DIV sign rules: quotient sign = XOR of operand signs; remainder sign = dividend sign (truncating division).
REQ-027 DIV with 0x80000000 / 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-028 Divisor zero (DIV or DIVU) SHALL yield HI=rs_data as captured and LO=0xFFFFFFFF.
REQ-029 hilo_we SHALL write the selected register at the edge when the FSM is in IDLE or DONE, and SHALL be ignored in RUN.
REQ-030 hilo_we together with an accepted start in IDLE SHALL perform both; the later result overwrites HI/LO at E32.
REQ-031 The result commit at E32 and hilo_we cannot coincide, because E32 is a RUN-state edge.
REQ-032 hi/lo SHALL hold their value whenever they are not being written.

Reset
REQ-033 On reset=0, asynchronously: FSM to IDLE; busy=0, done=0, hi=0, lo=0; counter and internal accumulators cleared.
REQ-034 Reset during RUN SHALL abort the operation: no done pulse and no hi/lo update.
REQ-035 The first start SHALL be honoured on the first rising edge after reset returns to 1.

Verification
REQ-036 MULT rs=0xFFFFFFFE, rt=0x00000003 -> busy high 32 cycles, done pulse at E32, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-037 MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-038 Divide cases:
  - DIV rs=0xFFFFFFF9 (-7), rt=0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU rs=7, rt=0 -> LO=0xFFFFFFFF, HI=0x00000007, still 32 cycles.
REQ-039 Ignore and abort cases:
  - start plus a new op, and hilo_we, applied mid-RUN -> both ignored; the original result is committed unchanged.
  - reset=0 at RUN cycle 10 -> busy=0, hi=lo=0, no done pulse.
REQ-040 hilo_we=1, hilo_sel=1, hilo_wdata=0x12345678 in IDLE -> hi=0x12345678 next edge, lo unchanged.
REQ-041 hilo_we in DONE -> hi/lo write taken on that edge.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO result registers.
// Every operation takes exactly 32 RUN cycles, one bit per cycle.
module mult_div_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        hilo_we,
    input  logic        hilo_sel,
    input  logic [31:0] hilo_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  cnt;
    logic        is_div_q;
    logic        neg_q;
    logic        neg_r;
    logic        div_zero;
    logic [31:0] m_q;
    logic [31:0] rs_q;
    logic [63:0] acc;

    logic        accept;
    logic        finish;
    logic        signed_op;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_abs;
    logic [31:0] b_abs;

    logic [32:0] msum;
    logic [63:0] mul_nxt;
    logic [32:0] dshift;
    logic [32:0] dsub;
    logic        ge;
    logic [31:0] rnew;
    logic [63:0] div_nxt;
    logic [63:0] acc_nxt;

    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign accept    = (state == IDLE) && start;
    assign finish    = (state == RUN) && (cnt == 5'd31);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);

    assign signed_op = ~op[0];
    assign a_neg     = signed_op & rs_data[31];
    assign b_neg     = signed_op & rt_data[31];
    assign a_abs     = a_neg ? (32'd0 - rs_data) : rs_data;
    assign b_abs     = b_neg ? (32'd0 - rt_data) : rt_data;

    // Shift-add: acc = {partial product, remaining multiplier bits}
    assign msum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m_q} : 33'd0);
    assign mul_nxt = {msum, acc[31:1]};

    // Restoring divide: acc = {remainder, dividend/quotient bits}
    assign dshift  = {acc[63:32], acc[31]};
    assign dsub    = dshift - {1'b0, m_q};
    assign ge      = (dshift >= {1'b0, m_q});
    assign rnew    = ge ? dsub[31:0] : dshift[31:0];
    assign div_nxt = {rnew, acc[30:0], ge};

    assign acc_nxt = is_div_q ? div_nxt : mul_nxt;

    assign prod = neg_q ? (64'd0 - acc_nxt) : acc_nxt;
    assign quo  = neg_q ? (32'd0 - acc_nxt[31:0]) : acc_nxt[31:0];
    assign rem  = neg_r ? (32'd0 - acc_nxt[63:32]) : acc_nxt[63:32];

    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div_q) begin
            if (div_zero) begin
                res_hi = rs_q;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= 5'd0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            m_q      <= 32'd0;
            rs_q     <= 32'd0;
            acc      <= 64'd0;
        end else if (accept) begin
            cnt      <= 5'd0;
            is_div_q <= op[1];
            neg_q    <= a_neg ^ b_neg;
            neg_r    <= a_neg;
            div_zero <= (rt_data == 32'd0);
            rs_q     <= rs_data;
            if (op[1]) begin
                m_q <= b_abs;
                acc <= {32'd0, a_abs};
            end else begin
                m_q <= a_abs;
                acc <= {32'd0, b_abs};
            end
        end else if (state == RUN) begin
            cnt <= cnt + 5'd1;
            acc <= acc_nxt;
        end
    end

    // Commit happens only on a RUN edge, so it never collides with hilo_we
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (finish) begin
            hi <= res_hi;
            lo <= res_lo;
        end else if (hilo_we && (state != RUN)) begin
            if (hilo_sel) begin
                hi <= hilo_wdata;
            end else begin
                lo <= hilo_wdata;
            end
        end
    end

endmodule
